// File: rtl/cnn_pool_stream_tx_pkg.sv
// Shared types and defaults for the pooled-feature transmit path.
// Defaults track CO / OF_BW / POOL_POS of the CNN core.
package cnn_pool_stream_tx_pkg;

    localparam int unsigned PoolCoDefault   = 3;
    localparam int unsigned PoolOfBwDefault = 34;
    localparam int unsigned PoolPosDefault  = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StStream  = 2'd1,
        StWaitAck = 2'd2
    } rd_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_pool_pingpong_mem.sv
// Two-bank pooled-map store: one write port, one registered read port.
// The read register doubles as the beat data output, so it is reset to zero.
module cnn_pool_pingpong_mem
    import cnn_pool_stream_tx_pkg::*;
#(
    parameter int unsigned DataW = 102,
    parameter int unsigned Depth = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_en_i,
    input  logic                        wr_bank_i,
    input  logic [cnt_width(Depth)-1:0] wr_addr_i,
    input  logic [DataW-1:0]            wr_data_i,
    input  logic                        rd_en_i,
    input  logic                        rd_bank_i,
    input  logic [cnt_width(Depth)-1:0] rd_addr_i,
    output logic [DataW-1:0]            rd_data_o
);

    localparam int unsigned AddrW = cnt_width(Depth);

    logic [DataW-1:0] mem_q [2*Depth];
    logic [DataW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
        end
    end

    assign rd_data_o = rd_data_q;

    logic unused_addr_w;
    assign unused_addr_w = (AddrW == 0);

endmodule

// File: rtl/cnn_pool_stream_tx.sv
// Double-buffers 4x4 pooled maps and replays each as POS back-to-back beats,
// holding off the next frame until the accumulator acknowledges the last one.
module cnn_pool_stream_tx
    import cnn_pool_stream_tx_pkg::*;
#(
    parameter int unsigned CO    = PoolCoDefault,
    parameter int unsigned OF_BW = PoolOfBwDefault,
    parameter int unsigned POS   = PoolPosDefault
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_in_valid,
    input  logic [CO*OF_BW-1:0]   i_in_pool,
    output logic                  o_in_ready,
    input  logic                  i_acc_valid,
    output logic                  o_ot_valid,
    output logic [CO*OF_BW-1:0]   o_ot_pool,
    output logic                  o_overflow,
    output logic                  o_busy
);

    localparam int unsigned    CntW    = cnt_width(POS);
    localparam int unsigned    DataW   = CO * OF_BW;
    localparam logic [CntW-1:0] LastCnt = CntW'(POS - 1);

    rd_state_e       state_q, state_d;
    logic            wr_bank_q, wr_bank_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
    logic            rd_bank_q, rd_bank_d;
    logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]      full_q, full_d;
    logic            valid_q, valid_d;
    logic            overflow_q, overflow_d;
    logic            busy_q, busy_d;
    logic            wr_fire;
    logic            rd_en;

    assign o_in_ready = !full_q[wr_bank_q];
    assign wr_fire    = i_in_valid && o_in_ready;

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_bank_d  = rd_bank_q;
        rd_cnt_d   = rd_cnt_q;
        full_d     = full_q;
        rd_en      = 1'b0;
        overflow_d = overflow_q || (i_in_valid && !o_in_ready);

        if (wr_fire) begin
            if (wr_cnt_q == LastCnt) begin
                wr_cnt_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        // Writer is blocked on a full bank, so this clear never hits the bank just set.
        unique case (state_q)
            StIdle: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = StStream;
                    rd_cnt_d = '0;
                end
            end
            StStream: begin
                rd_en = 1'b1;
                if (rd_cnt_q == LastCnt) begin
                    rd_cnt_d          = '0;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    state_d           = StWaitAck;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            StWaitAck: begin
                if (i_acc_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        valid_d = rd_en;
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
            full_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_bank_q  <= rd_bank_d;
            rd_cnt_q   <= rd_cnt_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    cnn_pool_pingpong_mem #(
        .DataW (DataW),
        .Depth (POS)
    ) u_mem (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (wr_fire),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (wr_cnt_q),
        .wr_data_i (i_in_pool),
        .rd_en_i   (rd_en),
        .rd_bank_i (rd_bank_q),
        .rd_addr_i (rd_cnt_q),
        .rd_data_o (o_ot_pool)
    );

    assign o_ot_valid = valid_q;
    assign o_overflow = overflow_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_cnn_pool_stream_tx.sv
// Randomized bench for cnn_pool_stream_tx against a frame-queue reference model.
module tb_cnn_pool_stream_tx;

    localparam int unsigned CO    = 3;
    localparam int unsigned OF_BW = 34;
    localparam int unsigned POS   = 16;
    localparam int unsigned DW    = CO * OF_BW;
    localparam int          Never = 1 << 30;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_in_valid = 1'b0;
    logic [DW-1:0] i_in_pool = '0;
    logic          i_acc_valid = 1'b0;
    logic          o_in_ready, o_ot_valid, o_overflow, o_busy;
    logic [DW-1:0] o_ot_pool;

    cnn_pool_stream_tx #(
        .CO    (CO),
        .OF_BW (OF_BW),
        .POS   (POS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_in_valid  (i_in_valid),
        .i_in_pool   (i_in_pool),
        .o_in_ready  (o_in_ready),
        .i_acc_valid (i_acc_valid),
        .o_ot_valid  (o_ot_valid),
        .o_ot_pool   (o_ot_pool),
        .o_overflow  (o_overflow),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: words in arrival order, completion edge of each stored frame,
    // and the edge of the last honoured acknowledge.
    int            cyc = 0;
    logic [DW-1:0] exp_q [$];
    int            comp_q [$];
    int            beat_idx = 0;
    int            wr_m = 0;
    int            ack_edge = 0;
    int            frames_done = 0;
    bit            wait_ack = 0;
    bit            ovf_m = 0;
    bit            end_req = 0;
    bit            end_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int exp_start;
        bit exp_valid, exp_busy, exp_ready;
        if (!reset_n) begin
            check("rst_ot_valid", DW'(o_ot_valid), '0);
            check("rst_ot_pool", o_ot_pool, '0);
            check("rst_in_ready", DW'(o_in_ready), DW'(1));
            check("rst_overflow", DW'(o_overflow), '0);
            check("rst_busy", DW'(o_busy), '0);
            exp_q.delete();
            comp_q.delete();
            beat_idx = 0;
            wr_m     = 0;
            wait_ack = 0;
            ovf_m    = 0;
            ack_edge = cyc;
        end else begin
            exp_start = Never;
            if (comp_q.size() > 0 && !wait_ack)
                exp_start = ((comp_q[0] > ack_edge) ? comp_q[0] : ack_edge) + 2;
            exp_valid = (beat_idx > 0) || (cyc == exp_start);
            exp_busy  = (beat_idx > 0) || wait_ack || (exp_start != Never && cyc >= exp_start - 1);
            check("ot_valid", DW'(o_ot_valid), DW'(exp_valid));
            check("busy", DW'(o_busy), DW'(exp_busy));
            if (o_ot_valid && exp_valid) begin
                check("ot_pool", o_ot_pool, exp_q[0]);
                void'(exp_q.pop_front());
                beat_idx++;
                if (beat_idx == POS) begin
                    beat_idx = 0;
                    void'(comp_q.pop_front());
                    wait_ack = 1;
                    frames_done++;
                end
            end
            exp_ready = (comp_q.size() < 2);
            check("in_ready", DW'(o_in_ready), DW'(exp_ready));
            check("overflow", DW'(o_overflow), DW'(ovf_m));
            if (i_in_valid && !exp_ready) ovf_m = 1;
            if (i_in_valid && exp_ready) begin
                exp_q.push_back(i_in_pool);
                wr_m++;
                if (wr_m == POS) begin
                    wr_m = 0;
                    comp_q.push_back(cyc + 1);
                end
            end
            if (wait_ack && i_acc_valid) begin
                wait_ack = 0;
                ack_edge = cyc + 1;
            end
            if (end_req && !end_done) begin
                check("drained_frames", DW'(comp_q.size()), '0);
                check("drained_words", DW'(exp_q.size()), '0);
                end_done = 1;
            end
        end
    end

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int c = 0; c < CO; c++) w[c*OF_BW +: OF_BW] = OF_BW'({$urandom, $urandom});
        return w;
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] d, input bit ack);
        @(posedge clk);
        #1;
        i_in_valid  = v;
        i_in_pool   = d;
        i_acc_valid = ack;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0);
    endtask

    task automatic ack_after(input int delay);
        for (int i = 0; i < 200 && !wait_ack; i++) step(0, '0, 0);
        idle_cycles(delay);
        step(0, '0, 1);
        step(0, '0, 0);
    endtask

    task automatic write_frame_rand();
        for (int p = 0; p < POS; p++) step(1, rand_word(), 0);
        step(0, '0, 0);
    endtask

    initial begin
        logic [DW-1:0] w;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single frame with position/channel tagged words
        for (int p = 0; p < POS; p++) begin
            for (int c = 0; c < CO; c++) w[c*OF_BW +: OF_BW] = OF_BW'(p * 16 + c);
            step(1, w, 0);
        end
        step(0, '0, 0);
        ack_after(5);

        // Two frames back to back, delayed ack, stale ack mid-stream
        for (int p = 0; p < 2 * POS; p++) step(1, rand_word(), 0);
        step(0, '0, 0);
        ack_after(20);
        for (int i = 0; i < 50 && beat_idx != 5; i++) step(0, '0, 0);
        step(0, '0, 1);
        step(0, '0, 0);
        ack_after(10);

        // Random traffic with random (often stale) acks
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 5) == 0);
        step(0, '0, 0);

        // Backpressure: no acks, continuous offers beyond two banks
        for (int i = 0; i < 3 * POS + 8; i++) step(1, rand_word(), 0);
        step(0, '0, 0);
        for (int i = 0; i < 600 && (comp_q.size() > 0 || wait_ack || wr_m > 0); i++)
            step(0, '0, wait_ack);
        step(0, '0, 0);

        // Reset in the middle of a stream
        write_frame_rand();
        for (int i = 0; i < 60 && beat_idx != 7; i++) step(0, '0, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        i_in_valid  = 1'b0;
        i_acc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Fresh frame after reset
        write_frame_rand();
        ack_after(3);
        for (int i = 0; i < 200 && (comp_q.size() > 0 || wait_ack); i++) step(0, '0, wait_ack);
        idle_cycles(4);

        end_req = 1;
        for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
        if (!end_done) begin
            errors++;
            $display("FAIL end_handshake: got 0 expected 1");
        end
        if (frames_done < 10) begin
            errors++;
            $display("FAIL frame_count: got %0d expected at least 10", frames_done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_pool_stream_tx.md
# cnn_pool_stream_tx

Transmit side of the pooled-feature stream into the fully-connected accumulator. It captures one 4x4 max-pool map per frame: 16 positions, `CO` channels each. It double-buffers the frames and replays each one to the accumulator as exactly 16 back-to-back valid beats. Before it starts the next frame, it waits for the accumulator's result pulse, which keeps the accumulator's position counter aligned with frame boundaries.

## Interface
- `CO`, default 3, channels per beat (`` `CO`` from defines_cnn_core.vh)
- `OF_BW`, default 34, bits per channel value (`` `OF_BW``)
- `POS`, default 16, pooled positions per frame; must be a power of 2
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `i_in_valid`  in  1  pooled word offered by the pooling stage
- `i_in_pool`  in  CO*OF_BW  pooled word; channel c is at [c*OF_BW +: OF_BW]
- `o_in_ready`  out  1  write bank can accept; a word is accepted when valid & ready
- `i_acc_valid`  in  1  accumulator result pulse; acts as the frame acknowledge
- `o_ot_valid`  out  1  beat valid to accumulator
- `o_ot_pool`  out  CO*OF_BW  beat data, same channel packing as `i_in_pool`
- `o_overflow`  out  1  sticky flag: a word was offered while `o_in_ready`=0
- `o_busy`  out  1  read FSM is not in IDLE

## Operation
- **Storage:** two banks, each POS x CO*OF_BW. Per-bank `full` flags are cleared on reset.
- **Write side**
  - `wr_bank` and `wr_cnt` (log2 POS bits) start at 0.
  - `o_in_ready` = !full[wr_bank], combinational from registered state.
  - On each accepted word: store it at mem[wr_bank][wr_cnt], then wr_cnt++.
  - On the accept with wr_cnt==POS-1: set full[wr_bank], wrap wr_cnt to 0, toggle wr_bank.
  - Offered-but-not-accepted words are dropped; they set `o_overflow` until reset.
- **Read FSM:** states IDLE, STREAM, WAIT_ACK.
  - IDLE: if full[rd_bank], go to STREAM with rd_cnt=0.
  - STREAM: each cycle, register mem[rd_bank][rd_cnt] into `o_ot_pool` with `o_ot_valid`=1, then rd_cnt++.
  - When the beat at rd_cnt==POS-1 is loaded: clear full[rd_bank], toggle rd_bank, go to WAIT_ACK.
  - WAIT_ACK: `o_ot_valid`=0. On `i_acc_valid`=1, go to IDLE.
  - `i_acc_valid` in IDLE or STREAM is ignored.
- **Outputs:** all outputs are registered except `o_in_ready`.
- **Data path:** bits are passed through unchanged. No arithmetic, no sign handling.
- **Simultaneous set/clear:** a clear of full[b] by the reader and a set of full[b] by the writer cannot coincide, because the writer is blocked while full[b]=1. A bank freed at edge E is writable from the cycle after E.
- **Reset (any state, including mid-stream):**
  - FSM goes to IDLE; all counters, bank pointers and full flags go to 0.
  - Outputs: `o_ot_valid`=0, `o_ot_pool`=0, `o_overflow`=0, `o_busy`=0, `o_in_ready`=1.
  - Memory contents are don't-care.

## Timing
- Let E0 be the edge that accepts the final (POS-th) word of a frame.
  - At E1, the FSM enters STREAM.
  - `o_ot_valid` is high after edges E2..E(POS+1), i.e. 16 consecutive cycles with no gaps.
  - At E(POS+1), the FSM enters WAIT_ACK and the bank becomes free.
- Fill-to-first-beat latency: 2 cycles.
- Beat order: position 0..POS-1, matching the accumulator's position-major weight indexing.
- With both banks full, `o_in_ready` stays low until the edge that loads the last beat of the bank being streamed.
- Minimum frame period: max(POS writes, POS+2+ack latency) cycles.

## Structure
- `CO`, `OF_BW`, `W_BW`, `ACC_BW` remain in defines_cnn_core.vh. Add `` `POOL_POS`` (16) to the same file.
- FSM state encodings are local parameters.
- Sub-module `cnn_pool_pingpong_mem`:
  - Two-bank synchronous-read RAM with one write port and one read port.
  - Contains no flags; flags and counters stay in the top.

## Test plan
- **Single frame:** after reset, write values p*16+c (position p, channel c) over 16 cycles. Required: beats 2..17 cycles after the last write carry the same words in order; exactly 16 valid beats; `o_busy`=1 until the ack.
- **Ack gating:** write two frames back to back with the ack delayed 20 cycles. Required: the second frame's first beat appears 2 cycles after `i_acc_valid`, and never before it.
- **Backpressure and overflow:** write 3 frames with no ack. Required: `o_in_ready`=0 after 32 accepts. A 33rd offer sets `o_overflow`=1 and the word is lost; the stored frames are unaltered.
- **Stale ack:** pulse `i_acc_valid` during STREAM. Required: it is ignored, and the FSM still waits in WAIT_ACK for a new pulse.
- **Reset mid-stream:** assert `reset_n`=0 at beat 7. Required: `o_ot_valid` goes to 0 immediately, `o_in_ready`=1, and a fresh frame streams correctly afterwards.
- **Integration with the accumulator:** use fixed weights and an all-ones pooled map. Required: the accumulator's result matches the reference sum per channel, with one result per frame.
